// File: rtl/hazard_ctrl.sv
// Load-use / MDU-busy hazard detection, MDU sequencing and branch flush control.
// Optional stall statistics counter is built only when HAZ_STALL_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MD_MULT_CYC = 4,
  parameter int unsigned MD_DIV_CYC  = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_IF_ID_r,
  input  logic [4:0]       rt_IF_ID_r,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic [4:0]       rt_ID_EX_r,
  input  logic             EX_ctrl_MemRd,
  input  logic             ID_is_md,
  input  logic             ID_md_div,
  input  logic             ID_reads_hilo,
  input  logic             EX_branch_taken,
  output logic             PC_wr,
  output logic             IF_ID_wr,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             md_start,
  output logic             md_div,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] MultCyc = MD_MULT_CYC[7:0];
  localparam logic [7:0] DivCyc  = MD_DIV_CYC[7:0];

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     fsm_q, fsm_d;
  logic [7:0] busy_cnt_q, busy_cnt_d;

  logic ld_use, md_haz, stall;

  assign ld_use = EX_ctrl_MemRd && (rt_ID_EX_r != 5'd0) &&
                  ((ID_uses_rs && (rs_IF_ID_r == rt_ID_EX_r)) ||
                   (ID_uses_rt && (rt_IF_ID_r == rt_ID_EX_r)));
  assign md_haz = (fsm_q == StBusy) && (ID_reads_hilo || ID_is_md);
  assign stall  = (ld_use || md_haz) && !EX_branch_taken;

  always_comb begin
    PC_wr       = 1'b1;
    IF_ID_wr    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    md_start    = 1'b0;
    md_div      = 1'b0;
    md_busy     = (fsm_q == StBusy);
    if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (stall) begin
      PC_wr       = 1'b0;
      IF_ID_wr    = 1'b0;
      ID_EX_flush = 1'b1;
    end else if (ID_is_md) begin
      md_start = 1'b1;
      md_div   = ID_md_div;
    end
  end

  // A running operation is never aborted by a branch flush; only reset clears it.
  always_comb begin
    fsm_d      = fsm_q;
    busy_cnt_d = busy_cnt_q;
    unique case (fsm_q)
      StIdle: begin
        if (md_start) begin
          fsm_d      = StBusy;
          busy_cnt_d = ID_md_div ? DivCyc : MultCyc;
        end
      end
      StBusy: begin
        if (busy_cnt_q == 8'd1) begin
          fsm_d      = StIdle;
          busy_cnt_d = 8'd0;
        end else begin
          busy_cnt_d = busy_cnt_q - 8'd1;
        end
      end
      default: begin
        fsm_d      = StIdle;
        busy_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= StIdle;
      busy_cnt_q <= 8'd0;
    end else begin
      fsm_q      <= fsm_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stall cycles; branch-flush cycles have stall low.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with CNT_W=3
// shares the stimulus to exercise stall counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_IF_ID_r, rt_IF_ID_r, rt_ID_EX_r;
  logic        ID_uses_rs, ID_uses_rt, EX_ctrl_MemRd;
  logic        ID_is_md, ID_md_div, ID_reads_hilo, EX_branch_taken;
  logic        PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush, md_start, md_div, md_busy;
  logic [31:0] stall_cnt;
  logic        PC_wr3, IF_ID_wr3, IF_ID_flush3, ID_EX_flush3, md_start3, md_div3, md_busy3;
  logic [2:0]  stall_cnt3;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stalls = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .rs_IF_ID_r(rs_IF_ID_r), .rt_IF_ID_r(rt_IF_ID_r),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .rt_ID_EX_r(rt_ID_EX_r),
    .EX_ctrl_MemRd(EX_ctrl_MemRd), .ID_is_md(ID_is_md), .ID_md_div(ID_md_div),
    .ID_reads_hilo(ID_reads_hilo), .EX_branch_taken(EX_branch_taken), .PC_wr(PC_wr),
    .IF_ID_wr(IF_ID_wr), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .md_start(md_start), .md_div(md_div), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .rs_IF_ID_r(rs_IF_ID_r), .rt_IF_ID_r(rt_IF_ID_r),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .rt_ID_EX_r(rt_ID_EX_r),
    .EX_ctrl_MemRd(EX_ctrl_MemRd), .ID_is_md(ID_is_md), .ID_md_div(ID_md_div),
    .ID_reads_hilo(ID_reads_hilo), .EX_branch_taken(EX_branch_taken), .PC_wr(PC_wr3),
    .IF_ID_wr(IF_ID_wr3), .IF_ID_flush(IF_ID_flush3), .ID_EX_flush(ID_EX_flush3),
    .md_start(md_start3), .md_div(md_div3), .md_busy(md_busy3), .stall_cnt(stall_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Order: {PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush, md_start, md_div, md_busy}
  function automatic logic [31:0] outs();
    return {25'd0, PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush, md_start, md_div, md_busy};
  endfunction

  function automatic logic [31:0] exp_cnt(input int n, input int w);
`ifdef HAZ_STALL_CNT_EN
    longint sat;
    sat = (64'd1 << w) - 1;
    return (n > sat) ? 32'(sat) : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic clear_in();
    rs_IF_ID_r = 5'd0; rt_IF_ID_r = 5'd0; rt_ID_EX_r = 5'd0;
    ID_uses_rs = 1'b0; ID_uses_rt = 1'b0; EX_ctrl_MemRd = 1'b0;
    ID_is_md = 1'b0; ID_md_div = 1'b0; ID_reads_hilo = 1'b0; EX_branch_taken = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cnt"}, stall_cnt, exp_cnt(exp_stalls, 32));
    check({tag, "_cnt3"}, {29'd0, stall_cnt3}, exp_cnt(exp_stalls, 3));
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    #12;
    check("rst_outs", outs(), 32'b1100000);
    check_cnts("rst");
    rst = 1'b1;
    cyc();

    // Load-use on rs: exactly one bubble.
    rt_ID_EX_r = 5'd3; EX_ctrl_MemRd = 1'b1; rs_IF_ID_r = 5'd3; ID_uses_rs = 1'b1;
    @(negedge clk); check("lu_rs", outs(), 32'b0001000);
    cyc(); exp_stalls++;
    EX_ctrl_MemRd = 1'b0;
    @(negedge clk); check("lu_after", outs(), 32'b1100000);
    cyc();

    // $zero destination, unused operand: no stall. rt match: stall.
    clear_in(); EX_ctrl_MemRd = 1'b1; ID_uses_rs = 1'b1;
    @(negedge clk); check("lu_zero", outs(), 32'b1100000);
    cyc();
    clear_in(); EX_ctrl_MemRd = 1'b1; rt_ID_EX_r = 5'd7; rs_IF_ID_r = 5'd7;
    @(negedge clk); check("lu_unused", outs(), 32'b1100000);
    cyc();
    rt_IF_ID_r = 5'd7; ID_uses_rt = 1'b1;
    @(negedge clk); check("lu_rt", outs(), 32'b0001000);
    cyc(); exp_stalls++;

    // mult then dependent mflo: 4 stalls, leaves on cycle 5.
    clear_in(); ID_is_md = 1'b1;
    @(negedge clk); check("mult_start", outs(), 32'b1100100);
    cyc();
    clear_in(); ID_reads_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check($sformatf("mflo_stall%0d", i), outs(), 32'b0001001);
      cyc(); exp_stalls++;
    end
    @(negedge clk); check("mflo_go", outs(), 32'b1100000);
    check_cnts("five");
    cyc();

    // div followed by div: 32 stalls, second issues on cycle 33.
    clear_in(); ID_is_md = 1'b1; ID_md_div = 1'b1;
    @(negedge clk); check("div1_start", outs(), 32'b1100110);
    cyc();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (outs() !== 32'b0001001) check($sformatf("div_hold%0d", i), outs(), 32'b0001001);
      cyc(); exp_stalls++;
    end
    n_cmp++;
    @(negedge clk); check("div2_start", outs(), 32'b1100110);
    check_cnts("div");
    cyc();

    // Branch during BUSY with md_haz and ld_use: branch wins, MDU keeps running.
    EX_ctrl_MemRd = 1'b1; rt_ID_EX_r = 5'd4; rs_IF_ID_r = 5'd4; ID_uses_rs = 1'b1;
    EX_branch_taken = 1'b1;
    @(negedge clk); check("br_busy", outs(), 32'b1111001);
    cyc();
    clear_in();
    @(negedge clk); check("busy_free", outs(), 32'b1100001);
    check_cnts("br");
    // busy_cnt now 31; run down to 10.
    for (int i = 0; i < 21; i++) cyc();
    @(negedge clk); check("busy_at10", outs(), 32'b1100001);
    @(posedge clk); #1;
    // busy_cnt 9 here; one more edge already passed, so re-align: reset is async anyway.
    rst = 1'b0;
    #1;
    check("rst_async_busy", {31'd0, md_busy}, 32'd0);
    exp_stalls = 0;
    check_cnts("rst2");
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Branch in IDLE with md in ID and load-use: no md_start.
    ID_is_md = 1'b1; EX_ctrl_MemRd = 1'b1; rt_ID_EX_r = 5'd2; rt_IF_ID_r = 5'd2;
    ID_uses_rt = 1'b1; EX_branch_taken = 1'b1;
    @(negedge clk); check("br_idle", outs(), 32'b1111000);
    cyc();
    clear_in(); ID_is_md = 1'b1;
    @(negedge clk); check("mult_after_rst", outs(), 32'b1100100);
    cyc();
    clear_in();
    @(negedge clk); check("mult_busy", outs(), 32'b1100001);
    cyc();

    // Build up 9 stalls from reset to saturate the 3-bit counter.
    clear_in(); EX_ctrl_MemRd = 1'b1; rt_ID_EX_r = 5'd9; rs_IF_ID_r = 5'd9; ID_uses_rs = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(); exp_stalls++;
    end
    @(negedge clk); check_cnts("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multi-cycle scheduler for the 5-stage MIPS core; sits beside the forwarding unit and covers the hazards forwarding cannot resolve. Detects load-use hazards, sequences the multi-cycle multiply/divide unit (MDU) with an internal latency counter, and applies branch flushes. Drives PC write enable, IF/ID write/flush and the ID/EX bubble, and issues MDU start pulses.

## Interface
Parameters:
- MD_MULT_CYC, 4, MDU cycles for mult/multu (1..255)
- MD_DIV_CYC, 32, MDU cycles for div/divu (1..255)
- CNT_W, 32, width of stall_cnt

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- rs_IF_ID_r  in  5  rs field of the instruction in ID
- rt_IF_ID_r  in  5  rt field of the instruction in ID
- ID_uses_rs  in  1  ID instruction reads rs
- ID_uses_rt  in  1  ID instruction reads rt
- rt_ID_EX_r  in  5  destination register of the instruction in EX
- EX_ctrl_MemRd  in  1  EX instruction is a load
- ID_is_md  in  1  ID instruction is mult/multu/div/divu
- ID_md_div  in  1  qualifies ID_is_md: 1 = divide, 0 = multiply
- ID_reads_hilo  in  1  ID instruction is mfhi/mflo
- EX_branch_taken  in  1  branch/jump resolved taken in EX
- PC_wr  out  1  PC write enable
- IF_ID_wr  out  1  IF/ID register write enable
- IF_ID_flush  out  1  zero IF/ID at the next edge
- ID_EX_flush  out  1  insert a bubble into ID/EX at the next edge
- md_start  out  1  one-cycle MDU start pulse
- md_div  out  1  operation select accompanying md_start
- md_busy  out  1  MDU result not yet valid
- stall_cnt  out  CNT_W  stall-cycle counter (see Configuration)

## Operation
- Register state: fsm in {IDLE, BUSY}; 8-bit busy_cnt.
- ld_use = EX_ctrl_MemRd & (rt_ID_EX_r != 0) & ((ID_uses_rs & rs_IF_ID_r == rt_ID_EX_r) | (ID_uses_rt & rt_IF_ID_r == rt_ID_EX_r)).
- md_haz = (fsm == BUSY) & (ID_reads_hilo | ID_is_md).
- stall = (ld_use | md_haz) & ~EX_branch_taken.
- Branch has top priority: EX_branch_taken -> PC_wr=1, IF_ID_wr=1, IF_ID_flush=1, ID_EX_flush=1, md_start=0.
- Stall: PC_wr=0, IF_ID_wr=0, IF_ID_flush=0, ID_EX_flush=1.
- Otherwise: PC_wr=1, IF_ID_wr=1, both flushes 0.
- md_start = ID_is_md & ~stall & ~EX_branch_taken; md_div = ID_md_div when md_start, else 0.
- IDLE: md_start -> BUSY, busy_cnt <= ID_md_div ? MD_DIV_CYC : MD_MULT_CYC.
- BUSY: busy_cnt decrements each cycle; at busy_cnt == 1 the next edge -> IDLE, busy_cnt <= 0. md_start cannot occur in BUSY (md_haz stalls it).
- md_busy = (fsm == BUSY). Branch flushes never abort a running MDU operation.

## Timing
- All decode/control outputs are combinational from the current inputs and fsm; only fsm, busy_cnt and stall_cnt are registered.
- Reset (rst low, asynchronous): fsm=IDLE, busy_cnt=0, stall_cnt=0; outputs then read PC_wr=1, IF_ID_wr=1, both flushes 0, md_start=0, md_div=0, md_busy=0.
- Reset asserted mid-BUSY aborts the operation immediately; md_busy drops without waiting for a clock edge.
- Load-use costs exactly 1 bubble: on the next cycle the load is in MEM and ld_use clears.
- md_start at cycle T -> md_busy high T+1..T+N (N = selected latency); a dependent mfhi/mflo or md instruction held in ID leaves ID at T+N+1.
- A second md instruction issues back-to-back at T+N+1 at the earliest.
- ld_use and md_haz together: one stall per cycle, no double counting.
- A branch taken in the same cycle as ld_use or md_haz: the branch wins, the ID instruction is flushed, no md_start.

## Configuration
- HAZ_STALL_CNT_EN defined: stall_cnt increments on every clock where stall=1 and saturates at all-ones. Branch-flush cycles are not counted.
- Not defined: no counter logic is built, and stall_cnt is tied to 0.

## Test plan
- lw $3 in EX (rt_ID_EX_r=3, MemRd=1), add in ID reading rs=3 -> one cycle with PC_wr=0, IF_ID_wr=0, ID_EX_flush=1, then normal flow. Same case with rt_ID_EX_r=0 -> no stall.
- mult in ID while IDLE -> md_start=1, md_div=0; md_busy high exactly 4 cycles; mflo entering ID on the next cycle is stalled 4 cycles and leaves ID on cycle 5.
- div followed by div -> second held 32 cycles, md_start pulses again on cycle 33 with md_div=1.
- EX_branch_taken=1 while an md instruction is in ID and a load-use condition holds -> IF_ID_flush=1, ID_EX_flush=1, PC_wr=1, md_start=0.
- Drive rst low during BUSY at busy_cnt=10 -> md_busy=0 immediately; after release, mult is accepted at once.
- With HAZ_STALL_CNT_EN: 1 load-use stall + 4 mflo stalls -> stall_cnt=5; CNT_W=3 with 9 stalls -> stall_cnt=7 (saturated). Without the macro -> stall_cnt=0 throughout.
